acc_drain: RTL and testbench
============================

ACC_DRAIN -- requirements
Module: acc_drain

Interface
REQ-001 Parameter DW, default 32: accumulator word width in bits.
REQ-002 Parameter N, default 16: number of accumulator lanes drained per tile.
REQ-003 Port clk, input, 1: single clock; all state SHALL change on its rising edge only.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port acc_in, input, DW x [0:N-1] unpacked array: PE-array accumulator outputs, lane i = PE i.
REQ-006 Port capture, input, 1: single-cycle request to snapshot acc_in and start draining.
REQ-007 Port relu_en, input, 1: sampled with capture; selects ReLU clamping for that tile.
REQ-008 Port out_data, output, DW: current drained word.
REQ-009 Port out_idx, output, clog2(N): lane index of out_data.
REQ-010 Port out_valid, output, 1: out_data/out_idx/out_last are valid.
REQ-011 Port out_ready, input, 1: downstream accepts the word.
REQ-012 Port out_last, output, 1: current word is lane N-1.
REQ-013 Port busy, output, 1: a tile is held or streaming.
REQ-014 Port overrun, output, 1: one-cycle pulse, capture dropped.

Function
REQ-015 The block SHALL have two states: IDLE (busy=0, out_valid=0) and STREAM (busy=1, out_valid=1).
REQ-016 In IDLE, capture=1 SHALL load all N lanes of acc_in and relu_en into snapshot registers, set index to 0, and enter STREAM on the same edge.
REQ-017 Latency: capture sampled at edge k SHALL give out_valid=1, out_idx=0, out_data=lane 0 immediately after edge k.
REQ-018 A beat transfers on an edge where out_valid=1 and out_ready=1; index SHALL then increment by 1.
REQ-019 With out_valid=1 and out_ready=0, out_data, out_idx, out_last SHALL hold stable until the beat transfers.
REQ-020 out_last SHALL equal 1 exactly when out_idx = N-1 and out_valid=1.
REQ-021 On transfer of the out_last beat, the block SHALL return to IDLE and index SHALL wrap to 0.
REQ-022 Snapshot registers SHALL change only on accepted captures; changes on acc_in during STREAM SHALL NOT affect out_data.
REQ-023 ReLU: with latched relu_en=1, a lane whose bit DW-1 is 1 (negative in two's complement) SHALL output 0; otherwise it is passed unchanged. With relu_en=0, all lanes pass unchanged.
REQ-024 No width change: out_data SHALL be exactly DW bits, with no truncation or saturation beyond REQ-023.
REQ-025 Capture in STREAM, other than in the case of REQ-026, SHALL be ignored; overrun SHALL pulse high for one cycle after that edge, and the stream SHALL be unaffected.
REQ-026 Capture on the same edge as transfer of the out_last beat SHALL be accepted back-to-back: new snapshot, index 0, state stays STREAM, no overrun.
REQ-027 Back-to-back operation SHALL sustain one beat per cycle when out_ready=1 continuously; tile throughput is N cycles.
REQ-028 All outputs SHALL be driven from registers; there SHALL be no combinational path from out_ready or capture to any output.

Reset
REQ-029 While rst=1, the block SHALL immediately (asynchronously) force state IDLE, index 0, out_valid=0, out_last=0, busy=0, overrun=0, out_data=0, out_idx=0, snapshot=0, latched relu_en=0.
REQ-030 Reset asserted mid-stream SHALL abandon the tile; after release, no beats of it SHALL appear.
REQ-031 The first capture at least one edge after rst deasserts SHALL be accepted normally.

Verification
REQ-032 Lanes acc_in[i]=i*0x11111111; capture with relu_en=0; out_ready=1 -> 16 consecutive beats, idx 0..15, data matches, out_last on beat 15 only, busy drops the next cycle.
REQ-033 Lane 3=0xFFFFFFF0, lane 4=0x7FFFFFFF; capture with relu_en=1 -> beat 3 data 0x00000000, beat 4 0x7FFFFFFF; same tile with relu_en=0 -> beat 3 0xFFFFFFF0.
REQ-034 out_ready toggled pseudo-randomly, and acc_in changed every cycle after capture -> data/idx stable while stalled, all 16 snapshot values delivered in order, none duplicated.
REQ-035 Capture at beat 5, and capture coincident with the accepted beat-15 transfer -> first gives overrun pulse and stream unchanged; second starts new tile idx 0 with no gap and no overrun.
REQ-036 rst pulsed while out_idx=7 and out_ready=0 -> out_valid=0 and busy=0 at once; after release no beats until a new capture, which then streams from idx 0.

Source files
------------

// File: rtl/acc_drain.sv
// Snapshots an N-lane accumulator tile and streams it out one lane per beat
// over a valid/ready interface, with optional per-tile ReLU clamping.
module acc_drain #(
   parameter  int DW = 32,
   parameter  int N  = 16,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] acc_in [0:N-1],
   input  logic          capture,
   input  logic          relu_en,
   output logic [DW-1:0] out_data,
   output logic [IW-1:0] out_idx,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          busy,
   output logic          overrun
);

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [DW-1:0] snap_q [0:N-1];
   logic [DW-1:0] snap_d [0:N-1];
   logic          relu_q, relu_d;
   logic [DW-1:0] data_q, data_d;
   logic          last_q, last_d;
   logic          ovr_q, ovr_d;
   logic [IW-1:0] idx_nxt;
   logic          xfer;

   function automatic logic [DW-1:0] relu_fn(input logic [DW-1:0] v, input logic en);
      return (en && v[DW-1]) ? '0 : v;
   endfunction

   assign xfer    = (state_q == STREAM) && out_ready;
   assign idx_nxt = idx_q + IW'(1);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      snap_d  = snap_q;
      relu_d  = relu_q;
      data_d  = data_q;
      last_d  = last_q;
      ovr_d   = 1'b0;
      // A capture is accepted when idle, or when the final beat leaves on this edge.
      if (capture && ((state_q == IDLE) || (xfer && last_q))) begin
         state_d = STREAM;
         snap_d  = acc_in;
         relu_d  = relu_en;
         idx_d   = '0;
         data_d  = relu_fn(acc_in[0], relu_en);
         last_d  = (N == 1);
      end else begin
         if (capture) ovr_d = 1'b1;
         if (xfer) begin
            if (last_q) begin
               state_d = IDLE;
               idx_d   = '0;
               data_d  = '0;
               last_d  = 1'b0;
            end else begin
               idx_d  = idx_nxt;
               data_d = relu_fn(snap_q[idx_nxt], relu_q);
               last_d = (idx_nxt == IW'(N - 1));
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         snap_q  <= '{default: '0};
         relu_q  <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         relu_q  <= relu_d;
         data_q  <= data_d;
         last_q  <= last_d;
         ovr_q   <= ovr_d;
      end
   end

   assign out_data  = data_q;
   assign out_idx   = idx_q;
   assign out_valid = (state_q == STREAM);
   assign busy      = (state_q == STREAM);
   assign out_last  = last_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain: full drain, ReLU, stalls with changing inputs,
// overrun and back-to-back captures, and mid-stream reset.
module tb_acc_drain;

   localparam int DW = 32;
   localparam int N  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] acc_in [0:N-1];
   logic          capture, relu_en, out_ready;
   logic [DW-1:0] out_data;
   logic [3:0]    out_idx;
   logic          out_valid, out_last, busy, overrun;

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] exp_tile [0:N-1];

   acc_drain #(.DW(DW), .N(N)) dut (
      .clk(clk), .rst(rst), .acc_in(acc_in), .capture(capture), .relu_en(relu_en),
      .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int e;
      int cyc;
      logic r;

      rst = 1'b1; capture = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < N; i++) acc_in[i] = 32'h1234_0000 + i;
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy",  {31'd0, busy},      32'd0);
      chk("rst_last",  {31'd0, out_last},  32'd0);
      chk("rst_ovr",   {31'd0, overrun},   32'd0);
      chk("rst_data",  out_data,           32'd0);
      chk("rst_idx",   {28'd0, out_idx},   32'd0);
      step();
      rst = 1'b0;
      step();

      // Full drain, relu off, ready held high
      for (int i = 0; i < N; i++) acc_in[i] = i * 32'h1111_1111;
      capture = 1'b1; relu_en = 1'b0; out_ready = 1'b1;
      step();
      capture = 1'b0;
      for (int b = 0; b < N; b++) begin
         chk("drain_valid", {31'd0, out_valid}, 32'd1);
         chk("drain_idx",   {28'd0, out_idx},   32'(b));
         chk("drain_data",  out_data,           b * 32'h1111_1111);
         chk("drain_last",  {31'd0, out_last},  (b == N - 1) ? 32'd1 : 32'd0);
         step();
      end
      chk("drain_busy_end",  {31'd0, busy},      32'd0);
      chk("drain_valid_end", {31'd0, out_valid}, 32'd0);

      // ReLU on, then same tile with ReLU off
      acc_in[3] = 32'hFFFF_FFF0;
      acc_in[4] = 32'h7FFF_FFFF;
      capture = 1'b1; relu_en = 1'b1;
      step();
      capture = 1'b0; relu_en = 1'b0;
      for (int b = 0; b < N; b++) begin
         if (b == 3) chk("relu_b3", out_data, 32'h0000_0000);
         if (b == 4) chk("relu_b4", out_data, 32'h7FFF_FFFF);
         if (b == 9) chk("relu_b9", out_data, 32'h9999_9999 & 32'h0);
         step();
      end
      capture = 1'b1; relu_en = 1'b0;
      step();
      capture = 1'b0;
      for (int b = 0; b < N; b++) begin
         if (b == 3) chk("norelu_b3", out_data, 32'hFFFF_FFF0);
         if (b == 9) chk("norelu_b9", out_data, 32'h9999_9999);
         step();
      end

      // Random stalls while acc_in churns every cycle
      for (int i = 0; i < N; i++) begin
         acc_in[i]   = 32'hA000_0000 + 32'(i * 3);
         exp_tile[i] = 32'hA000_0000 + 32'(i * 3);
      end
      capture = 1'b1; relu_en = 1'b0;
      step();
      capture = 1'b0;
      e = 0;
      cyc = 0;
      while (e < N && cyc < 300) begin
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_idx",   {28'd0, out_idx},   32'(e));
         chk("stall_data",  out_data,           exp_tile[e]);
         r = 1'($urandom_range(0, 1));
         out_ready = r;
         for (int i = 0; i < N; i++) acc_in[i] = $urandom;
         step();
         if (r) e++;
         cyc++;
      end
      chk("stall_beats", 32'(e), 32'(N));
      chk("stall_busy_end", {31'd0, busy}, 32'd0);

      // Overrun mid-stream, then back-to-back capture on the last beat
      for (int i = 0; i < N; i++) acc_in[i] = 32'h100 + i;
      out_ready = 1'b1; capture = 1'b1;
      step();
      capture = 1'b0;
      for (int b = 0; b < N; b++) begin
         chk("ovr_idx", {28'd0, out_idx}, 32'(b));
         if (b == 5) begin
            for (int i = 0; i < N; i++) acc_in[i] = 32'h200 + i;
            capture = 1'b1;
         end
         if (b == N - 1) begin
            for (int i = 0; i < N; i++) acc_in[i] = 32'h300 + i;
            capture = 1'b1;
         end
         step();
         capture = 1'b0;
         if (b == 5) begin
            chk("ovr_pulse", {31'd0, overrun},  32'd1);
            chk("ovr_idx6",  {28'd0, out_idx},  32'd6);
            chk("ovr_data6", out_data,          32'h106);
         end
         if (b == 6) chk("ovr_clear", {31'd0, overrun}, 32'd0);
      end
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      chk("b2b_idx",   {28'd0, out_idx},   32'd0);
      chk("b2b_data",  out_data,           32'h300);
      chk("b2b_ovr",   {31'd0, overrun},   32'd0);
      step();
      chk("b2b_data1", out_data, 32'h301);
      for (int b = 1; b < N; b++) step();
      chk("b2b_busy_end", {31'd0, busy}, 32'd0);

      // Reset while stalled at idx 7
      for (int i = 0; i < N; i++) acc_in[i] = 32'h400 + i;
      capture = 1'b1;
      step();
      capture = 1'b0;
      for (int b = 0; b < 7; b++) step();
      out_ready = 1'b0;
      step();
      chk("pre_rst_idx",  {28'd0, out_idx}, 32'd7);
      chk("pre_rst_data", out_data,         32'h407);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_busy",  {31'd0, busy},      32'd0);
      chk("mid_rst_idx",   {28'd0, out_idx},   32'd0);
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
      end
      capture = 1'b1;
      step();
      capture = 1'b0;
      chk("post_rst_idx",  {28'd0, out_idx}, 32'd0);
      chk("post_rst_data", out_data,         32'h400);
      step();
      chk("post_rst_data1", out_data, 32'h401);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
